// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and fetch-stage types, common to fetch and the control unit.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // Field order mirrors the R-type layout, so a cast of the raw word splits it
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [31:0] instr);
        return instr_fields_t'(instr);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: req/ready request phase, rvalid/rdata response phase.
interface instruction_fetch_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [31:0]     rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instr_fields.sv
// Combinational split of an instruction word into decode fields; shared with decode.
module instr_fields
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opCode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);
    instr_fields_t f;

    assign f      = split_instr(instr);
    assign opCode = f.opcode;
    assign funct3 = f.funct3;
    assign funct7 = f.funct7;
    assign rd     = f.rd;
    assign rs1    = f.rs1;
    assign rs2    = f.rs2;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, one-entry IF/ID slot, decode back-pressure and redirect.
module instruction_fetch #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master imem,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                id_ready,
    output logic                id_valid,
    output logic [31:0]         id_instr,
    output logic [XLEN-1:0]     id_pc,
    output logic [6:0]          id_opCode,
    output logic [2:0]          id_funct3,
    output logic [6:0]          id_funct7,
    output logic [4:0]          id_rd,
    output logic [4:0]          id_rs1,
    output logic [4:0]          id_rs2
);
    import riscv_pkg::*;

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] slot_pc_n;
    logic [31:0]     instr_n;
    logic            valid_n;
    logic            req;
    logic [XLEN-1:0] tgt;

    assign tgt       = redirect_pc & ~XLEN'(3);
    assign imem.req  = req & ~reset;
    assign imem.addr = pc;

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        valid_n   = id_valid;
        instr_n   = id_instr;
        slot_pc_n = id_pc;
        req       = 1'b0;
        case (state)
            S_REQ: begin
                req = 1'b1;
                if (redirect) begin
                    pc_n = tgt;
                    // the old address was accepted; its response must be thrown away
                    if (imem.ready) state_n = S_DROP;
                end else if (imem.ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_n    = tgt;
                    state_n = imem.rvalid ? S_REQ : S_DROP;
                end else if (imem.rvalid) begin
                    instr_n   = imem.rdata;
                    slot_pc_n = pc;
                    pc_n      = pc + XLEN'(4);
                    valid_n   = 1'b1;
                    state_n   = S_FULL;
                end
            end
            S_FULL: begin
                // no request on a redirect cycle, so nothing stale is left in flight
                req = id_ready & ~redirect;
                if (redirect) begin
                    valid_n = 1'b0;
                    instr_n = NOP_INSTR;
                    pc_n    = tgt;
                    state_n = S_REQ;
                end else if (id_ready) begin
                    valid_n = 1'b0;
                    state_n = imem.ready ? S_WAIT : S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) pc_n = tgt;
                if (imem.rvalid) state_n = S_REQ;
            end
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            id_valid <= valid_n;
            id_instr <= instr_n;
            id_pc    <= slot_pc_n;
        end
    end

    instr_fields u_fields (
        .instr  (id_instr),
        .opCode (id_opCode),
        .funct3 (id_funct3),
        .funct7 (id_funct7),
        .rd     (id_rd),
        .rs1    (id_rs1),
        .rs2    (id_rs2)
    );

    property p_addr_aligned;
        @(posedge clk) disable iff (reset) imem.req |-> (imem.addr[1:0] == 2'b00);
    endproperty
    assert property (p_addr_aligned);

    property p_slot_held;
        @(posedge clk) disable iff (reset)
            (state == S_FULL && !id_ready && !redirect) |=> ($stable(id_instr) && $stable(id_pc));
    endproperty
    assert property (p_slot_held);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scenarios plus a randomized run against a program-order reference of the fetch stream.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opCode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;

    instruction_fetch_if #(.XLEN(32)) imem ();

    instruction_fetch #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_opCode   (id_opCode),
        .id_funct3   (id_funct3),
        .id_funct7   (id_funct7),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // per-cycle input plan, applied at the falling edge by cycle()
    bit          p_reset, p_rdy, p_redir, p_idr;
    logic [31:0] p_tgt;

    // memory model: single outstanding read with mem_lat cycles to rvalid
    int          mem_lat   = 1;
    int          pend_left = 0;
    logic [31:0] pend_addr = '0;
    bit          accepted;
    logic [31:0] acc_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic cycle();
        bit rv;
        @(negedge clk);
        reset       = p_reset;
        imem.ready  = p_rdy;
        redirect    = p_redir;
        redirect_pc = p_tgt;
        id_ready    = p_idr;
        rv          = (pend_left == 1);
        imem.rvalid = rv;
        imem.rdata  = rv ? memw(pend_addr) : $urandom;
        #1;
        accepted = imem.req && imem.ready;
        acc_addr = imem.addr;
        if (pend_left > 0) pend_left--;
        if (accepted) begin
            pend_left = mem_lat;
            pend_addr = imem.addr;
        end
        if (p_reset) pend_left = 0;
    endtask

    task automatic test_reset();
        p_reset = 1; p_rdy = 1; p_redir = 0; p_idr = 0; p_tgt = '0; mem_lat = 1;
        cycle();
        cycle();
        ntests++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b want 0", imem.req); end
        ntests++; if (id_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        ntests++; if (id_instr !== NOP) begin nfail++; $display("FAIL reset_instr: got %h want %h", id_instr, NOP); end
        ntests++; if (id_pc !== 32'h0) begin nfail++; $display("FAIL reset_idpc: got %h want 0", id_pc); end
        ntests++; if (id_opCode !== 7'h13 || id_rd !== 5'd0 || id_funct3 !== 3'd0)
            begin nfail++; $display("FAIL reset_fields: got op=%h rd=%h f3=%h want 13/0/0", id_opCode, id_rd, id_funct3); end
    endtask

    task automatic test_stream();
        int na = 0;
        bit exp_v;
        p_reset = 0; p_rdy = 1; p_idr = 1; mem_lat = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            exp_v = (i >= 2) && (i % 2 == 0);
            ntests++; if (id_valid !== exp_v) begin nfail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, id_valid, exp_v); end
            if (accepted) begin
                ntests++; if (acc_addr !== 32'(na * 4)) begin nfail++; $display("FAIL stream_addr[%0d]: got %h want %h", na, acc_addr, 32'(na * 4)); end
                na++;
            end
            if (exp_v) begin
                ntests++; if (id_pc !== 32'((i / 2 - 1) * 4) || id_instr !== memw(32'((i / 2 - 1) * 4)))
                    begin nfail++; $display("FAIL stream_slot[%0d]: got pc=%h instr=%h want pc=%h", i, id_pc, id_instr, 32'((i / 2 - 1) * 4)); end
            end
        end
        ntests++; if (na != 4) begin nfail++; $display("FAIL stream_count: got %0d want 4", na); end
    endtask

    task automatic test_backpressure();
        p_idr = 0;
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'hC) begin nfail++; $display("FAIL bp_first: got v=%b pc=%h want 1/c", id_valid, id_pc); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            ntests++;
            if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== memw(32'hC) || imem.req !== 1'b0 || imem.addr !== 32'h10) begin
                nfail++;
                $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h req=%b addr=%h want 1/c/%h/0/10",
                         i, id_valid, id_pc, id_instr, imem.req, imem.addr, memw(32'hC));
            end
        end
        p_idr = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'h10) begin nfail++; $display("FAIL bp_release: got acc=%b addr=%h want 1/10", accepted, acc_addr); end
        p_idr = 0;
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin nfail++; $display("FAIL bp_next: got v=%b pc=%h want 1/10", id_valid, id_pc); end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3; p_idr = 1; p_rdy = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'h14) begin nfail++; $display("FAIL rw_accept: got acc=%b addr=%h want 1/14", accepted, acc_addr); end
        p_idr = 0; p_redir = 1; p_tgt = 32'h100;
        cycle();
        ntests++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL rw_waitreq: got %b want 0", imem.req); end
        p_redir = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            ntests++; if (id_valid !== 1'b0 || imem.req !== 1'b0) begin nfail++; $display("FAIL rw_drop[%0d]: got v=%b req=%b want 0/0", i, id_valid, imem.req); end
        end
        mem_lat = 1;
        cycle();
        ntests++; if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin nfail++; $display("FAIL rw_refetch: got req=%b addr=%h want 1/100", imem.req, imem.addr); end
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== memw(32'h100))
            begin nfail++; $display("FAIL rw_slot: got v=%b pc=%h instr=%h want 1/100/%h", id_valid, id_pc, id_instr, memw(32'h100)); end
    endtask

    task automatic test_redirect_full();
        p_redir = 1; p_tgt = 32'h203; p_idr = 1;
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin nfail++; $display("FAIL rf_before: got v=%b pc=%h want 1/100", id_valid, id_pc); end
        p_redir = 0; p_idr = 0;
        cycle();
        ntests++; if (id_valid !== 1'b0 || id_instr !== NOP || id_opCode !== 7'h13)
            begin nfail++; $display("FAIL rf_flush: got v=%b instr=%h op=%h want 0/%h/13", id_valid, id_instr, id_opCode, NOP); end
        ntests++; if (imem.req !== 1'b1 || imem.addr !== 32'h200) begin nfail++; $display("FAIL rf_addr: got req=%b addr=%h want 1/200", imem.req, imem.addr); end
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin nfail++; $display("FAIL rf_slot: got v=%b pc=%h want 1/200", id_valid, id_pc); end
    endtask

    task automatic test_ready_stall();
        p_idr = 1; p_rdy = 0;
        cycle();
        ntests++; if (accepted) begin nfail++; $display("FAIL rs_consume: got acc=%b want 0", accepted); end
        p_idr = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            ntests++; if (imem.req !== 1'b1 || imem.addr !== 32'h204 || id_valid !== 1'b0)
                begin nfail++; $display("FAIL rs_hold[%0d]: got req=%b addr=%h v=%b want 1/204/0", i, imem.req, imem.addr, id_valid); end
        end
        p_rdy = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'h204) begin nfail++; $display("FAIL rs_accept: got acc=%b addr=%h want 1/204", accepted, acc_addr); end
        cycle();
        ntests++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL rs_wait: got req=%b want 0", imem.req); end
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h204) begin nfail++; $display("FAIL rs_slot: got v=%b pc=%h want 1/204", id_valid, id_pc); end
    endtask

    task automatic test_wrap_and_reset();
        p_redir = 1; p_tgt = 32'hFFFF_FFFC;
        cycle();
        p_redir = 0; p_rdy = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL wr_top: got acc=%b addr=%h want 1/fffffffc", accepted, acc_addr); end
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) begin nfail++; $display("FAIL wr_slot: got v=%b pc=%h want 1/fffffffc", id_valid, id_pc); end
        p_idr = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'h0) begin nfail++; $display("FAIL wr_wrap: got acc=%b addr=%h want 1/0", accepted, acc_addr); end
        p_idr = 0;
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin nfail++; $display("FAIL wr_zero: got v=%b pc=%h want 1/0", id_valid, id_pc); end
        mem_lat = 3; p_idr = 1;
        cycle();
        ntests++; if (!accepted || acc_addr !== 32'h4) begin nfail++; $display("FAIL mr_accept: got acc=%b addr=%h want 1/4", accepted, acc_addr); end
        p_idr = 0; p_reset = 1;
        cycle();
        ntests++; if (imem.req !== 1'b0) begin nfail++; $display("FAIL mr_req: got %b want 0", imem.req); end
        p_reset = 0; mem_lat = 1;
        cycle();
        ntests++; if (id_valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h0)
            begin nfail++; $display("FAIL mr_after: got v=%b req=%b addr=%h want 0/1/0", id_valid, imem.req, imem.addr); end
        cycle();
        cycle();
        ntests++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== memw(32'h0))
            begin nfail++; $display("FAIL mr_slot: got v=%b pc=%h instr=%h want 1/0/%h", id_valid, id_pc, id_instr, memw(32'h0)); end
    endtask

    // Reference: the slot always shows the next instruction in program order;
    // a consume advances by 4, a redirect restarts the order at the aligned target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] w;
        int          consumed = 0;
        p_reset = 1; p_redir = 0; p_idr = 0; p_rdy = 0;
        cycle();
        p_reset = 0;
        exp_pc  = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            p_rdy   = ($urandom % 4) != 0;
            p_idr   = ($urandom % 10) < 7;
            p_redir = ($urandom % 20) == 0;
            p_tgt   = $urandom;
            mem_lat = $urandom_range(1, 3);
            cycle();
            if (imem.req) begin
                ntests++; if (imem.addr[1:0] !== 2'b00) begin nfail++; $display("FAIL rnd_align[%0d]: got %h want low bits 0", i, imem.addr); end
            end
            if (id_valid) begin
                w = memw(exp_pc);
                ntests++;
                if (id_pc !== exp_pc || id_instr !== w || id_opCode !== w[6:0] || id_funct3 !== w[14:12] ||
                    id_funct7 !== w[31:25] || id_rd !== w[11:7] || id_rs1 !== w[19:15] || id_rs2 !== w[24:20]) begin
                    nfail++;
                    $display("FAIL rnd_slot[%0d]: got pc=%h instr=%h op=%h rd=%h want pc=%h instr=%h", i, id_pc, id_instr, id_opCode, id_rd, exp_pc, w);
                end
            end
            if (p_redir) begin
                exp_pc = p_tgt & ~32'h3;
            end else if (id_valid && p_idr) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
        end
        ntests++; if (consumed < 200) begin nfail++; $display("FAIL rnd_progress: got %0d consumed want >= 200", consumed); end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem.ready = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_full();
        test_ready_stall();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
